// File: rtl/sdp_x_cfg_triosy_sched_pkg.sv
// Shared types and the round-robin pick helper for the SDP X cfg commit scheduler.
package sdp_x_cfg_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 32;
  localparam int MAX_REQ     = 8;
  localparam int PTR_W       = 3;

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } pick_t;

  // First set bit of vld at or after ptr, wrapping at n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] vld,
                                    input logic [PTR_W-1:0]   ptr,
                                    input int                 n);
    pick_t p;
    int    j;
    p = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = (int'(ptr) + k) % n;
      if ((k < n) && !p.found && vld[j]) begin
        p.found = 1'b1;
        p.idx   = PTR_W'(j);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/sdp_x_cfg_triosy_sched_if.sv
// Requester, core-side output and done/error bundle of the cfg commit scheduler.
interface sdp_x_cfg_triosy_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req_vld;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_rdy;
  logic                      out_vld;
  logic [DATA_W-1:0]         out_data;
  logic [ID_W-1:0]           out_id;
  logic                      out_rdy;
  logic                      core_stall;
  logic [NUM_REQ-1:0]        done_bawt;
  logic                      err_timeout;

  modport master (
    output req_vld, req_data, out_rdy, core_stall,
    input  req_rdy, out_vld, out_data, out_id, done_bawt, err_timeout
  );

  modport slave (
    input  req_vld, req_data, out_rdy, core_stall,
    output req_rdy, out_vld, out_data, out_id, done_bawt, err_timeout
  );
endinterface

// File: rtl/sdp_x_cfg_triosy_sched_arb.sv
// Combinational round-robin arbiter: one-hot grant and index of the first vld at/after ptr.
module sdp_x_rr_arb
  import sdp_x_cfg_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] vld,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               found
);

  pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_REQ'(vld), PTR_W'(ptr), NUM_REQ);
    found = pick.found;
    idx   = ID_W'(pick.idx);
    gnt   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = pick.found && (pick.idx == PTR_W'(i));
    end
  end

endmodule

// File: rtl/sdp_x_cfg_triosy_sched.sv
// Round-robin cfg commit scheduler: req_vld in IDLE -> out_vld next cycle, zero-bubble in BUSY;
// out_* held while !out_rdy, done held through core_stall, watchdog flags a stuck core.
module sdp_x_cfg_triosy_sched
  import sdp_x_cfg_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ID_W     = $clog2(NUM_REQ),
  parameter int TO_W     = 8,
  parameter int TO_LIMIT = 200
) (
  input logic                    nvdla_core_clk,
  input logic                    nvdla_core_rst,
  sdp_x_cfg_triosy_sched_if.slave bus
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ID_W-1:0]     out_id_q, out_id_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  done_hold_q, done_hold_d;
  logic [TO_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_found;
  logic                out_vld;
  logic                capture_en;
  logic                cap;
  logic [DATA_W-1:0]   win_data;
  logic [NUM_REQ-1:0]  req_rdy;
  logic [NUM_REQ-1:0]  acc;
  logic [NUM_REQ-1:0]  done_bawt;

  sdp_x_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .vld   (bus.req_vld),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .found (arb_found)
  );

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    rr_ptr_d   = rr_ptr_q;
    req_rdy    = '0;
    win_data   = '0;
    acc        = '0;

    out_vld    = (state_q == BUSY);
    capture_en = (state_q == IDLE) | bus.out_rdy;
    cap        = capture_en & arb_found;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) win_data = bus.req_data[i*DATA_W +: DATA_W];
    end

    if (capture_en) state_d = arb_found ? BUSY : IDLE;

    if (cap) begin
      out_data_d = win_data;
      out_id_d   = arb_idx;
      req_rdy    = arb_gnt;
      rr_ptr_d   = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
    end

    // done stays visible until the cycle after core_stall drops
    for (int i = 0; i < NUM_REQ; i++) begin
      acc[i] = out_vld & bus.out_rdy & (out_id_q == ID_W'(i));
    end
    done_bawt   = acc | done_hold_q;
    done_hold_d = done_bawt & {NUM_REQ{bus.core_stall}};

    if (out_vld && !bus.out_rdy) begin
      wd_cnt_d = (wd_cnt_q == TO_W'(TO_LIMIT)) ? wd_cnt_q : wd_cnt_q + TO_W'(1);
    end else begin
      wd_cnt_d = '0;
    end
    err_d = err_q | (wd_cnt_q == TO_W'(TO_LIMIT));
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= '0;
      done_hold_q <= '0;
      wd_cnt_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
      done_hold_q <= done_hold_d;
      wd_cnt_q    <= wd_cnt_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_rdy     = req_rdy;
  assign bus.out_vld     = out_vld;
  assign bus.out_data    = out_data_q;
  assign bus.out_id      = out_id_q;
  assign bus.done_bawt   = done_bawt;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_sdp_x_cfg_triosy_sched.sv
// Directed bench for the cfg commit scheduler; accepted commits are checked against a scoreboard.
module tb_sdp_x_cfg_triosy_sched;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 2;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sdp_x_cfg_triosy_sched_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) ifc ();

  sdp_x_cfg_triosy_sched #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W), .TO_W(8), .TO_LIMIT(200)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (ifc.slave)
  );

  function automatic logic [DATA_W-1:0] data_of(input int i);
    return 32'hA5A5_0000 | DATA_W'(i);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id);
    exp_t e;
    e.id  = ID_W'(id);
    e.dat = data_of(id);
    exp_q.push_back(e);
  endtask

  // settle, score any accept happening this cycle, then cross the clock edge
  task automatic step();
    exp_t e;
    #1;
    if (ifc.out_vld === 1'b1 && ifc.out_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_accept", 64'(ifc.out_id), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_id", 64'(ifc.out_id), 64'(e.id));
        chk("sb_data", 64'(ifc.out_data), 64'(e.dat));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    ifc.req_vld    = '0;
    ifc.out_rdy    = 1'b0;
    ifc.core_stall = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_out_vld", 64'(ifc.out_vld), 64'd0);
    chk("rst_out_data", 64'(ifc.out_data), 64'd0);
    chk("rst_out_id", 64'(ifc.out_id), 64'd0);
    chk("rst_req_rdy", 64'(ifc.req_rdy), 64'd0);
    chk("rst_done", 64'(ifc.done_bawt), 64'd0);
    chk("rst_err", 64'(ifc.err_timeout), 64'd0);
  endtask

  initial begin
    ifc.req_vld    = '0;
    ifc.out_rdy    = 1'b0;
    ifc.core_stall = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) ifc.req_data[i*DATA_W +: DATA_W] = data_of(i);

    // 1: single request, one-cycle latency, done on accept
    do_reset();
    ifc.req_vld = 4'b0100;
    ifc.out_rdy = 1'b1;
    #1;
    chk("t1_req_rdy", 64'(ifc.req_rdy), 64'h4);
    push(2);
    step();
    ifc.req_vld = '0;
    #1;
    chk("t1_out_vld", 64'(ifc.out_vld), 64'd1);
    chk("t1_out_id", 64'(ifc.out_id), 64'd2);
    chk("t1_out_data", 64'(ifc.out_data), 64'hA5A5_0002);
    chk("t1_done", 64'(ifc.done_bawt), 64'h4);
    step();
    chk("t1_idle", 64'(ifc.out_vld), 64'd0);
    chk("t1_done_clr", 64'(ifc.done_bawt), 64'd0);

    // 2: all requesting -> 0,1,2,3,0 with no bubble
    do_reset();
    ifc.req_vld = 4'b1111;
    ifc.out_rdy = 1'b1;
    push(0); push(1); push(2); push(3); push(0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t2_no_bubble", 64'(ifc.out_vld), 64'd1);
    end
    ifc.req_vld = '0;
    step();
    chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("t2_idle", 64'(ifc.out_vld), 64'd0);

    // 3: backpressure holds output stable, then next grant without bubble
    do_reset();
    ifc.req_vld = 4'b0011;
    ifc.out_rdy = 1'b0;
    #1;
    chk("t3_req_rdy0", 64'(ifc.req_rdy), 64'h1);
    push(0);
    step();
    ifc.req_vld = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_hold_rdy", 64'(ifc.req_rdy), 64'd0);
      chk("t3_hold_id", 64'(ifc.out_id), 64'd0);
      chk("t3_hold_data", 64'(ifc.out_data), 64'(data_of(0)));
      step();
    end
    ifc.out_rdy = 1'b1;
    #1;
    chk("t3_req_rdy1", 64'(ifc.req_rdy), 64'h2);
    push(1);
    step();
    ifc.req_vld = '0;
    #1;
    chk("t3_next_vld", 64'(ifc.out_vld), 64'd1);
    chk("t3_next_id", 64'(ifc.out_id), 64'd1);
    step();
    chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // 4: done held through core_stall, clears the cycle after it falls
    do_reset();
    ifc.req_vld = 4'b0010;
    ifc.out_rdy = 1'b1;
    push(1);
    step();
    ifc.req_vld    = '0;
    ifc.core_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_done_stall", 64'(ifc.done_bawt), 64'h2);
      step();
    end
    ifc.core_stall = 1'b0;
    #1;
    chk("t4_done_last", 64'(ifc.done_bawt), 64'h2);
    step();
    chk("t4_done_clr", 64'(ifc.done_bawt), 64'd0);

    // 5: watchdog sets after TO_LIMIT stalled cycles, sticky until reset
    do_reset();
    ifc.req_vld = 4'b0001;
    ifc.out_rdy = 1'b0;
    push(0);
    step();
    ifc.req_vld = '0;
    for (int c = 0; c < 190; c++) step();
    chk("t5_err_early", 64'(ifc.err_timeout), 64'd0);
    for (int c = 0; c < 15; c++) step();
    chk("t5_err_set", 64'(ifc.err_timeout), 64'd1);
    chk("t5_still_vld", 64'(ifc.out_vld), 64'd1);
    ifc.out_rdy = 1'b1;
    step();
    chk("t5_err_sticky", 64'(ifc.err_timeout), 64'd1);
    do_reset();

    // 6: reset mid-BUSY with a held done; pointer restarts at 0
    ifc.req_vld    = 4'b0110;
    ifc.out_rdy    = 1'b1;
    ifc.core_stall = 1'b1;
    #1;
    chk("t6_req_rdy1", 64'(ifc.req_rdy), 64'h2);
    push(1);
    step();
    ifc.req_vld = 4'b0100;
    #1;
    chk("t6_req_rdy2", 64'(ifc.req_rdy), 64'h4);
    chk("t6_done_acc", 64'(ifc.done_bawt), 64'h2);
    push(2);
    step();
    ifc.req_vld = '0;
    ifc.out_rdy = 1'b0;
    #1;
    chk("t6_done_held", 64'(ifc.done_bawt), 64'h2);
    chk("t6_busy_id", 64'(ifc.out_id), 64'd2);
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    #1;
    chk("t6_rst_vld", 64'(ifc.out_vld), 64'd0);
    chk("t6_rst_done", 64'(ifc.done_bawt), 64'd0);
    ifc.req_vld    = 4'b1111;
    ifc.out_rdy    = 1'b1;
    ifc.core_stall = 1'b0;
    #1;
    chk("t6_ptr0", 64'(ifc.req_rdy), 64'h1);
    push(0);
    step();
    ifc.req_vld = '0;
    step();
    chk("t6_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
